// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-master memory arbiter.
// State encodings and master index constants.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int CNT_W = 2;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-request picker; round robin, or fixed M0 priority
// when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_grant;

    always_comb begin
        grant = req[M0] ? M0 : M1;
    end
`else
    always_comb begin
        grant = M0;
        if (req[M0] && req[M1]) begin
            grant = ~last_grant;
        end else if (req[M1]) begin
            grant = M1;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the crossbar CPU port between M0 (LSU) and M1.
// Tie policy selected by MEM_ARB_FIXED_PRIO_EN (default round robin).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 30,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_m0_req,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic              i_m0_wren,
    input  logic [3:0]        i_m0_mask,
    output logic              o_m0_ack,
    input  logic              i_m1_req,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic              i_m1_wren,
    input  logic [3:0]        i_m1_mask,
    output logic              o_m1_ack,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic              o_wren,
    output logic [3:0]        o_mask,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              grant, grant_n;
    logic              win;
    logic              done;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] data_n;
    logic [3:0]        mask_n;
    logic              wren_n;

    // grant doubles as last_grant; reset to M1 so M0 wins the first tie
    rr_arb2 u_arb (
        .req        ({i_m1_req, i_m0_req}),
        .last_grant (grant),
        .grant      (win)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            grant  <= M1;
            o_addr <= '0;
            o_data <= '0;
            o_mask <= '0;
            o_wren <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            grant  <= grant_n;
            o_addr <= addr_n;
            o_data <= data_n;
            o_mask <= mask_n;
            o_wren <= wren_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        grant_n = grant;
        addr_n  = o_addr;
        data_n  = o_data;
        mask_n  = o_mask;
        wren_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_m0_req || i_m1_req) begin
                    grant_n = win;
                    addr_n  = (win == M1) ? i_m1_addr : i_m0_addr;
                    data_n  = (win == M1) ? i_m1_data : i_m0_data;
                    mask_n  = (win == M1) ? i_m1_mask : i_m0_mask;
                    wren_n  = (win == M1) ? i_m1_wren : i_m0_wren;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                if (o_wren) begin
                    state_n = IDLE;
                end else begin
                    cnt_n   = CNT_INIT;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // acks decode registered state only, so they cannot glitch
    assign done     = (state == ISSUE && o_wren) ||
                      (state == WAIT && cnt == '0);
    assign o_m0_ack = done && (grant == M0);
    assign o_m1_ack = done && (grant == M1);
    assign o_busy   = (state != IDLE);
    assign o_rdata  = i_data;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && o_busy) begin
            assert ((grant == M1) ? i_m1_req : i_m0_req)
            else $error("mem_arbiter: granted master dropped req before ack");
        end
    end
`endif

endmodule
